// File: rtl/correlator_pkg.sv
// Shared definitions for the correlator front-end stimulus blocks.
package correlator_pkg;

  localparam int unsigned CTRL_RUN  = 0;
  localparam int unsigned CTRL_MODE = 1;
  localparam int unsigned CTRL_W    = 2;

  localparam real PI = 3.141592653589793;

  // Offset register sits right after the per-channel phase registers
  function automatic int unsigned addr_offset(input int unsigned n);
    return n;
  endfunction

  // Control register follows the offset register
  function automatic int unsigned addr_ctrl(input int unsigned n);
    return n + 1;
  endfunction

  // Raised-sine table entry, rounded half away from zero; caller truncates to width
  function automatic logic [31:0] sine_entry(input int unsigned k, input int unsigned depth,
                                             input int unsigned res, input int unsigned off);
    real amp;
    real v;
    int  iv;
    amp = ((2.0 ** real'(res)) - 1.0 - 2.0 * real'(off)) / 2.0;
    v   = amp * (1.0 + $sin(2.0 * PI * real'(k) / real'(depth)));
    iv  = (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
    return 32'(iv);
  endfunction

endpackage

// File: rtl/sine_rom.sv
// Combinational sine table with one read port per channel.
module sine_rom
  import correlator_pkg::*;
#(
  parameter int unsigned TABLE_DEPTH    = 100,
  parameter int unsigned PWM_RESOLUTION = 8,
  parameter int unsigned TABLE_OFFSET   = 32,
  parameter int unsigned NUM_PORTS      = 1
) (
  input  logic [$clog2(TABLE_DEPTH)-1:0] idx  [NUM_PORTS],
  output logic [PWM_RESOLUTION-1:0]      data [NUM_PORTS]
);

  localparam int unsigned R    = PWM_RESOLUTION;
  localparam int unsigned IW   = $clog2(TABLE_DEPTH);
  localparam int unsigned ROWS = 1 << IW;

  logic [R-1:0] rom [ROWS];

  // Table rows fixed at elaboration; rows past the depth are padding
  for (genvar k = 0; k < ROWS; k++) begin : g_row
    if (k < TABLE_DEPTH) begin : g_used
      localparam logic [R-1:0] ENTRY = R'(sine_entry(k, TABLE_DEPTH, R, TABLE_OFFSET));
      assign rom[k] = ENTRY;
    end else begin : g_pad
      assign rom[k] = '0;
    end
  end

  // Independent read port per channel
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign data[p] = rom[idx[p]];
  end

endmodule

// File: rtl/sine_pwm_bank.sv
// Multi-channel sine-modulated PWM generator with per-channel phase and shared offset.
module sine_pwm_bank
  import correlator_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS   = 12,
  parameter int unsigned PWM_RESOLUTION = 8,
  parameter int unsigned TABLE_DEPTH    = 100,
  parameter int unsigned PRESCALE       = 5000,
  parameter int unsigned STEP_PERIODS   = 1,
  parameter int unsigned DEFAULT_OFFSET = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cfg_we,
  input  logic [$clog2(NUM_CHANNELS+2)-1:0] cfg_addr,
  input  logic [15:0]                       cfg_data,
  input  logic [NUM_CHANNELS-1:0]           mask,
  output logic [NUM_CHANNELS-1:0]           pulse_out,
  output logic                              frame_sync,
  output logic                              busy
);

  localparam int unsigned N           = NUM_CHANNELS;
  localparam int unsigned R           = PWM_RESOLUTION;
  localparam int unsigned AW          = $clog2(NUM_CHANNELS + 2);
  localparam int unsigned IW          = $clog2(TABLE_DEPTH);
  localparam int unsigned IW1         = IW + 1;
  localparam int unsigned PW          = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned SW          = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam int unsigned ADDR_OFFSET = addr_offset(N);
  localparam int unsigned ADDR_CTRL   = addr_ctrl(N);
  localparam int unsigned PHASE_STEP  = TABLE_DEPTH / N;

  logic [PW-1:0] presc;
  logic [R-1:0]  pwm_cnt;
  logic [SW-1:0] step_cnt;
  logic [IW-1:0] base_idx;
  logic [IW-1:0] phase [N];
  logic [R-1:0]  offset;
  logic          run;
  logic          mode;
  logic [R-1:0]  duty_q [N];

  logic          run_nxt;
  logic          mode_nxt;
  logic [R-1:0]  off_nxt;
  logic [IW-1:0] phase_nxt [N];
  logic [IW-1:0] phase_wr;
  logic [IW-1:0] rd_idx [N];
  logic [R-1:0]  tab [N];
  logic [R-1:0]  raw_duty [N];
  logic          tick;
  logic          period_end;
  logic          step_wrap;
  logic          idx_wrap;
  logic          unused_cfg;

  assign unused_cfg = ^cfg_data;
  assign phase_wr   = IW'(32'(cfg_data[7:0]) % TABLE_DEPTH);
  assign busy       = run;

  // Write-first view of the config registers for this cycle
  always_comb begin
    run_nxt   = run;
    mode_nxt  = mode;
    off_nxt   = offset;
    phase_nxt = phase;
    if (cfg_we) begin
      if (cfg_addr == AW'(ADDR_CTRL)) begin
        run_nxt  = cfg_data[CTRL_RUN];
        mode_nxt = cfg_data[CTRL_MODE];
      end else if (cfg_addr == AW'(ADDR_OFFSET)) begin
        off_nxt = cfg_data[R-1:0];
      end else begin
        for (int c = 0; c < N; c++) begin
          if (cfg_addr == AW'(c)) phase_nxt[c] = phase_wr;
        end
      end
    end
  end

  // Timing strobes; a stop written this cycle suppresses the tick
  assign tick       = run && run_nxt && (presc == PW'(PRESCALE - 1));
  assign period_end = tick && (pwm_cnt == '1);
  assign step_wrap  = period_end && (step_cnt == SW'(STEP_PERIODS - 1));
  assign idx_wrap   = step_wrap && (base_idx == IW'(TABLE_DEPTH - 1));

  // Config registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run    <= 1'b1;
      mode   <= 1'b0;
      offset <= R'(DEFAULT_OFFSET);
      for (int c = 0; c < N; c++) phase[c] <= IW'(PHASE_STEP * 32'(c));
    end else begin
      run    <= run_nxt;
      mode   <= mode_nxt;
      offset <= off_nxt;
      phase  <= phase_nxt;
    end
  end

  // Prescaler, PWM counter and table index; all held at zero while stopped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      pwm_cnt  <= '0;
      step_cnt <= '0;
      base_idx <= '0;
    end else if (!run_nxt) begin
      presc    <= '0;
      pwm_cnt  <= '0;
      step_cnt <= '0;
      base_idx <= '0;
    end else if (run) begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) pwm_cnt <= pwm_cnt + R'(1);
      if (period_end) step_cnt <= step_wrap ? '0 : step_cnt + SW'(1);
      if (step_wrap) base_idx <= (base_idx == IW'(TABLE_DEPTH - 1)) ? '0 : base_idx + IW'(1);
    end
  end

  // Per-channel table index, base plus phase modulo depth
  always_comb begin
    logic [IW:0] idx_sum;
    idx_sum = '0;
    for (int c = 0; c < N; c++) begin
      idx_sum = {1'b0, base_idx} + {1'b0, phase_nxt[c]};
      if (idx_sum >= IW1'(TABLE_DEPTH)) idx_sum = idx_sum - IW1'(TABLE_DEPTH);
      rd_idx[c] = idx_sum[IW-1:0];
    end
  end

  sine_rom #(
    .TABLE_DEPTH   (TABLE_DEPTH),
    .PWM_RESOLUTION(R),
    .TABLE_OFFSET  (DEFAULT_OFFSET),
    .NUM_PORTS     (N)
  ) u_rom (
    .idx (rd_idx),
    .data(tab)
  );

  // Candidate duty: table plus offset (or offset alone), saturated at full scale
  always_comb begin
    logic [R:0] sum;
    sum = '0;
    for (int c = 0; c < N; c++) begin
      sum         = mode_nxt ? {1'b0, off_nxt} : ({1'b0, tab[c]} + {1'b0, off_nxt});
      raw_duty[c] = sum[R] ? '1 : sum[R-1:0];
    end
  end

  // Duty only changes at a period boundary so no pulse is ever truncated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N; c++) duty_q[c] <= '0;
    end else if (period_end) begin
      duty_q <= raw_duty;
    end
  end

  // Output pins: gated duty compare and frame marker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_out  <= '0;
      frame_sync <= 1'b0;
    end else begin
      for (int c = 0; c < N; c++) pulse_out[c] <= run & ~mask[c] & (pwm_cnt < duty_q[c]);
      frame_sync <= idx_wrap;
    end
  end

endmodule
